// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the multi-cycle data memory.
// Access-type codes, FSM state encoding and the latency counter width.
package dm_pkg;

    // Access type codes carried on LStype
    localparam logic [2:0] LS_W  = 3'b000;  // word
    localparam logic [2:0] LS_H  = 3'b001;  // halfword, sign-extended on load
    localparam logic [2:0] LS_HU = 3'b010;  // halfword, zero-extended on load
    localparam logic [2:0] LS_B  = 3'b011;  // byte, sign-extended on load
    localparam logic [2:0] LS_BU = 3'b100;  // byte, zero-extended on load

    // Width of the access latency down-counter (LATENCY up to 15)
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } dm_state_t;

    // Codes above byte-unsigned have no meaning and are rejected
    function automatic logic ls_illegal(input logic [2:0] ls);
        return (ls > LS_BU);
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// dm_lane_merge: combinational lane logic for the data memory.
// Extracts and extends load data from a stored word, builds the merged
// word for a store (only the addressed lane replaced) and flags
// misaligned word/halfword accesses.
module dm_lane_merge (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_lstype,
    input  logic [31:0] i_wd,
    output logic [31:0] o_load,
    output logic [31:0] o_store,
    output logic        o_misalign
);
    import dm_pkg::*;

    logic [7:0]  w_bytes     [4];
    logic [7:0]  w_new_bytes [4];
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic        w_is_half;
    logic        w_is_byte;

    assign w_is_half = (i_lstype == LS_H) || (i_lstype == LS_HU);
    assign w_is_byte = (i_lstype == LS_B) || (i_lstype == LS_BU);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = i_word[8*gi +: 8];

            // Replace this byte lane when the store targets it, else keep it
            always_comb begin
                w_new_bytes[gi] = w_bytes[gi];
                if (i_lstype == LS_W) begin
                    w_new_bytes[gi] = i_wd[8*gi +: 8];
                end else if (w_is_half && (i_addr_lo[1] == 1'(gi / 2))) begin
                    w_new_bytes[gi] = i_wd[8*(gi % 2) +: 8];
                end else if (w_is_byte && (i_addr_lo == 2'(gi))) begin
                    w_new_bytes[gi] = i_wd[7:0];
                end
            end
        end
    endgenerate

    assign o_store = {w_new_bytes[3], w_new_bytes[2], w_new_bytes[1], w_new_bytes[0]};

    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte = w_bytes[i_addr_lo];

    // Select the addressed lane and sign- or zero-extend it
    always_comb begin
        o_load = 32'd0;
        case (i_lstype)
            LS_W:    o_load = i_word;
            LS_H:    o_load = {{16{w_half[15]}}, w_half};
            LS_HU:   o_load = {16'd0, w_half};
            LS_B:    o_load = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_load = {24'd0, w_byte};
            default: o_load = 32'd0;
        endcase
    end

    assign o_misalign = ((i_lstype == LS_W) && (i_addr_lo != 2'b00)) ||
                        (w_is_half && i_addr_lo[0]);

endmodule

// File: rtl/dm_multicycle.sv
// dm_multicycle: multi-cycle data memory with request/response handshake.
// After reset the array is cleared one word per cycle (CLEAR), then
// requests are accepted in IDLE or DONE, held for LATENCY cycles and
// answered with a one-cycle Valid strobe. Stores are read-modify-write
// and commit on the edge that ends DONE; a store followed directly by a
// load to the same word is forwarded around the RAM.
// Optional macro DM_TRACE_EN: print a trace line for every committed store.
module dm_multicycle #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [2:0]  LStype,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] Instr,
    output logic        Ready,
    output logic        Valid,
    output logic [31:0] RD,
    output logic        Err
);
    import dm_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

    dm_state_t r_state;
    dm_state_t w_state_next;

    logic [ADDR_W-1:0] r_clr_idx;
    logic [LAT_W-1:0]  r_cnt;

    // Latched request
    logic        r_we;
    logic [2:0]  r_lstype;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_instr;

    // Storage and its registered read port plus store-to-load bypass
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_ram_q;
    logic        r_fwd;
    logic [31:0] r_fwd_data;

    logic              w_accept;
    logic              w_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [31:0]       w_mem_wdata;
    logic [ADDR_W-1:0] w_raddr;
    logic [31:0]       w_word;
    logic [31:0]       w_load;
    logic [31:0]       w_store;
    logic              w_misalign;
    logic              w_range_err;
    logic              w_err;

    assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && Req && !Reset;
    assign w_range_err = ((r_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_err       = w_misalign || w_range_err || ls_illegal(r_lstype);
    // A reset arriving in DONE drops the pending store
    assign w_commit    = (r_state == DONE) && r_we && !w_err && !Reset;

    assign w_mem_we    = (r_state == CLEAR) || w_commit;
    assign w_mem_waddr = (r_state == CLEAR) ? r_clr_idx : r_addr[ADDR_W+1:2];
    assign w_mem_wdata = (r_state == CLEAR) ? 32'd0 : w_store;
    assign w_raddr     = Addr[ADDR_W+1:2];
    assign w_word      = r_fwd ? r_fwd_data : r_ram_q;

    dm_lane_merge u_lane (
        .i_word     (w_word),
        .i_addr_lo  (r_addr[1:0]),
        .i_lstype   (r_lstype),
        .i_wd       (r_wd),
        .o_load     (w_load),
        .o_store    (w_store),
        .o_misalign (w_misalign)
    );

    // RAM: single write port (clear or store commit), read at accept
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        if (w_accept) begin
            r_ram_q <= r_mem[w_raddr];
        end
    end

    // Latch the request; remember if the word is being written this same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we       <= 1'b0;
            r_lstype   <= LS_W;
            r_addr     <= 32'd0;
            r_wd       <= 32'd0;
            r_instr    <= 32'd0;
            r_fwd      <= 1'b0;
            r_fwd_data <= 32'd0;
        end else if (w_accept) begin
            r_we       <= WE;
            r_lstype   <= LStype;
            r_addr     <= Addr;
            r_wd       <= WD;
            r_instr    <= Instr;
            r_fwd      <= w_commit && (w_mem_waddr == w_raddr);
            r_fwd_data <= w_store;
        end
    end

    // Latency down-counter, loaded at accept and decremented while BUSY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= LAT_INIT;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Clear index walks the array once after every reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clr_idx <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR: begin
                if (r_clr_idx == '1) begin
                    w_state_next = IDLE;
                end
            end
            IDLE, DONE: begin
                if (Req) begin
                    w_state_next = (LATENCY == 1) ? DONE : BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt <= LAT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = CLEAR;
        endcase
    end

    // Outputs decoded from state and latched request only
    always_comb begin
        Ready = (r_state == IDLE) || (r_state == DONE);
        Valid = (r_state == DONE);
        Err   = (r_state == DONE) && w_err;
        RD    = 32'd0;
        if ((r_state == DONE) && !r_we && !w_err) begin
            RD = w_load;
        end
    end

`ifdef DM_TRACE_EN
    // Trace every committed store with its instruction and merged word
    always_ff @(posedge Clk) begin
        if (w_commit) begin
            $display("%d@%h: *%h <= %h", $time, r_instr, {r_addr[31:2], 2'b00}, w_store);
        end
    end
`else
    logic w_unused_instr;
    assign w_unused_instr = ^r_instr;
`endif

endmodule

// File: doc/dm_multicycle.md
# dm_multicycle

Parametrised multi-cycle data memory for the MEM stage, replacing the single-cycle DM with a request/response handshake, a configurable access latency, and a sequential post-reset clear. It performs word, halfword and byte loads and stores with sign or zero extension. Misaligned and out-of-range accesses are reported through an error flag instead of being silently performed. The pipeline stalls while `Ready` is low and captures load data when `Valid` is high.

## Interface
Parameters:
- `ADDR_W`, default 12: word-index width; depth is 2^ADDR_W words.
- `LATENCY`, default 2: cycles from accept edge to the `Valid` cycle; legal range 1..15.

Ports:
- `Clk`: input, 1 bit, clock.
- `Reset`: input, 1 bit, reset, synchronous, active-high.
- `Req`: input, 1 bit, access request; sampled only when `Ready`=1.
- `WE`: input, 1 bit, 1 = store, 0 = load.
- `LStype`: input, 3 bits, access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. For stores, 001/010 both mean halfword and 011/100 both mean byte. Codes 101–111 raise `Err`.
- `Addr`: input, 32 bits, byte address.
- `WD`: input, 32 bits, store data, taken from the low bits.
- `Instr`: input, 32 bits, instruction word, used for the trace only.
- `Ready`: output, 1 bit, able to accept a request this cycle.
- `Valid`: output, 1 bit, one-cycle response strobe.
- `RD`: output, 32 bits, extended load data; 0 for stores and errors.
- `Err`: output, 1 bit, access rejected; qualified by `Valid`.

## Operation
- **Reset values:** `Ready`=0, `Valid`=0, `RD`=0, `Err`=0. State is CLEAR and the clear index is 0.
- **CLEAR:** writes 0 to word `clr_idx`, one word per cycle.
  - `clr_idx` is held at 0 while `Reset`=1.
  - After writing word 2^ADDR_W−1, the block moves to IDLE.
- **IDLE** (`Ready`=1): if `Req`=1, latch `WE`, `LStype`, `Addr`, `WD` and `Instr`, load the latency counter with LATENCY−1, then:
  - go to DONE when LATENCY=1;
  - otherwise go to BUSY.
- **BUSY** (`Ready`=0): decrement the counter and go to DONE when it reaches 0.
- **DONE** (`Valid`=1, `Ready`=1):
  - A load drives `RD` from the stored word.
  - A store commits the merged word on the edge that ends DONE.
  - `Req` in DONE is accepted exactly as in IDLE, so back-to-back accesses are possible. Otherwise the next state is IDLE.
- **Err conditions** (no memory change, `RD`=0):
  - word access with `Addr[1:0]`≠0;
  - halfword access with `Addr[0]`=1;
  - `Addr[31:ADDR_W+2]`≠0;
  - illegal `LStype`.
- **Load extraction:**
  - Halfword lane is selected by `Addr[1]`; byte lane by `Addr[1:0]`.
  - Signed types replicate the lane MSB into the upper bits; unsigned types zero-fill.
- **Store merge:** read-modify-write of the addressed word. Only the selected lane is replaced, by `WD[15:0]` or `WD[7:0]`; the other bytes are preserved.
- **Reset during BUSY or DONE:** the pending access is dropped with no write, `Valid` is forced to 0, and the block returns to CLEAR.

## Timing
- For a request accepted at edge k, `Valid` is high in the cycle between edges k+LATENCY−1 and k+LATENCY, i.e. the LATENCY-th cycle after acceptance.
- A store's effect is visible to a load accepted at edge k+LATENCY or later.
- Throughput is one access per LATENCY cycles.
- `Ready` first rises 2^ADDR_W cycles after the first edge with `Reset`=0.
- `RD`, `Err` and `Valid` are registered or decoded from state only; there is no combinational path from `Req`.

## Configuration
- `DM_TRACE_EN` defined: each committed store prints `"%d@%h: *%h <= %h"` with `$time`, the latched `Instr`, the word-aligned address `{Addr[31:2],2'b00}` and the merged word. Errored accesses and CLEAR writes are not printed.
- `DM_TRACE_EN` undefined: no `$display`; functional behaviour is identical.

## Structure
- Package `dm_pkg`:
  - `LStype` codes as localparams;
  - state enum {CLEAR, IDLE, BUSY, DONE};
  - `LAT_W` = 4.
- Sub-module `dm_lane_merge` (combinational): from the word, `Addr[1:0]`, `LStype` and `WD`, it produces:
  - extracted load data;
  - the merged store word;
  - the misalignment flag.

## Test plan
- **Reset and clear:** pre-load garbage with ADDR_W=4, then `Reset` 3 cycles. Expect `Ready` low for exactly 16 cycles after release and every word reading 0.
- **Word store/load:** `sw` 0x12345678 to 0x8, then `lw` 0x8. Expect `RD`=0x12345678 with `Valid` exactly LATENCY cycles after each accept, for LATENCY=1 and LATENCY=3.
- **Byte and half merge with extension:**
  - `sb` 0xAB to 0x9 over 0x12345678 → word 0x1234AB78;
  - `lb` 0x9 → 0xFFFFFFAB;
  - `lbu` 0x9 → 0x000000AB;
  - `sh` 0x8001 to 0xA → word 0x8001AB78;
  - `lh` 0xA → 0xFFFF8001.
- **Errors:** each of `lw` 0x6, `lh` 0x5, `sw` to 0x40 (ADDR_W=4) and `LStype`=101 gives `Valid`=1, `Err`=1, `RD`=0, and memory unchanged.
- **Back-to-back:** `Req` held high through DONE for `sw` 0x0 then `lw` 0x0. Expect the second accept in the first DONE cycle and the load returning the new data.
- **Reset mid-access:** assert `Reset` during BUSY of an `sw`. Expect no `Valid`, CLEAR re-entered, and the target word 0 afterwards.
